// File: rtl/magia_l2_mem_wrapper.sv
// magia_l2_mem_wrapper: round-robin multi-port 32-bit byte-enabled L2 memory, one access per cycle.
// Optional exit-code monitor (eoc_o, exit_code_o) built when MAGIA_L2_EOC_MONITOR_EN is defined.
module magia_l2_mem_wrapper #(
    parameter int unsigned NumPorts = 4,
    parameter int unsigned MemAw    = 16,
    parameter int unsigned NumTiles = 16,
    parameter logic [31:0] EocAddr  = 32'hCC03_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumPorts-1:0]        req_i,
    input  logic [NumPorts-1:0]        we_i,
    input  logic [NumPorts-1:0][31:0]  addr_i,
    input  logic [NumPorts-1:0][31:0]  wdata_i,
    input  logic [NumPorts-1:0][3:0]   be_i,
    output logic [NumPorts-1:0]        gnt_o,
    output logic [NumPorts-1:0]        rvalid_o,
    output logic [NumPorts-1:0][31:0]  rdata_o
`ifdef MAGIA_L2_EOC_MONITOR_EN
    ,
    output logic                       eoc_o,
    output logic [NumTiles*16-1:0]     exit_code_o
`endif
);
    localparam int unsigned PW    = NumPorts > 1 ? $clog2(NumPorts) : 1;
    localparam int unsigned Words = 2 ** (MemAw - 2);

    logic [31:0]         mem_q [Words];
    logic [PW-1:0]       ptr_q, ptr_d, win, idx;
    logic                found, acc;
    logic [NumPorts-1:0] gnt, rvalid_q;
    logic [31:0]         rdata_q, w_addr, w_data;
    logic [3:0]          w_be;
    logic                w_we;
    logic [MemAw-3:0]    w_idx;
    logic                unused_addr;

    // Search starts at the priority pointer and wraps; first requester wins.
    always_comb begin
        gnt   = '0;
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NumPorts; i++) begin
            idx = PW'((int'(ptr_q) + i) % NumPorts);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        if (found && !rst_i) gnt[win] = 1'b1;
        ptr_d = found ? PW'((int'(win) + 1) % NumPorts) : ptr_q;
    end

    assign acc         = |gnt;
    assign w_we        = we_i[win];
    assign w_addr      = addr_i[win];
    assign w_data      = wdata_i[win];
    assign w_be        = be_i[win];
    assign w_idx       = w_addr[MemAw-1:2];
    assign unused_addr = ^{w_addr[31:MemAw], w_addr[1:0]};
    assign gnt_o       = gnt;
    assign rvalid_o    = rst_i ? '0 : rvalid_q;

    always_comb begin
        for (int p = 0; p < NumPorts; p++) rdata_o[p] = rvalid_o[p] ? rdata_q : '0;
    end

    always_ff @(posedge clk_i) begin
        if (acc && w_we)
            for (int k = 0; k < 4; k++)
                if (w_be[k]) mem_q[w_idx][8*k +: 8] <= w_data[8*k +: 8];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= gnt;
            rdata_q  <= (acc && !w_we) ? mem_q[w_idx] : '0;
        end
    end

`ifdef MAGIA_L2_EOC_MONITOR_EN
    logic [NumTiles-1:0][15:0] exit_q, exit_d;
    logic                      eoc_q, all_nz;

    // Each granted byte lane is matched against every slot byte on the full 32-bit address.
    always_comb begin
        exit_d = exit_q;
        all_nz = 1'b1;
        for (int i = 0; i < NumTiles; i++) begin
            all_nz = all_nz & (|exit_q[i]);
            for (int k = 0; k < 4; k++) begin
                if (acc && w_we && w_be[k]) begin
                    if ({w_addr[31:2], 2'(k)} == EocAddr + 32'(2 * i))
                        exit_d[i][7:0] = w_data[8*k +: 8];
                    if ({w_addr[31:2], 2'(k)} == EocAddr + 32'(2 * i + 1))
                        exit_d[i][15:8] = w_data[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exit_q <= '0;
            eoc_q  <= 1'b0;
        end else begin
            exit_q <= exit_d;
            eoc_q  <= all_nz;
        end
    end

    assign eoc_o       = eoc_q;
    assign exit_code_o = exit_q;
`endif
endmodule

// File: tb/tb_magia_l2_mem_wrapper.sv
// tb_magia_l2_mem_wrapper: directed scoreboard bench for magia_l2_mem_wrapper (4 ports, 2 tiles).
module tb_magia_l2_mem_wrapper;
    localparam logic [31:0] EOC = 32'hCC03_0000;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [3:0]       req_i, we_i, gnt_o, rvalid_o;
    logic [3:0][31:0] addr_i, wdata_i, rdata_o;
    logic [3:0][3:0]  be_i;
`ifdef MAGIA_L2_EOC_MONITOR_EN
    logic             eoc_o;
    logic [31:0]      exit_code_o;
`endif

    typedef struct {
        int          port;
        logic [31:0] data;
    } rsp_t;

    rsp_t        sb[$];
    logic [31:0] model [int];
    int          vectors = 0;
    int          errs = 0;

    always #5 clk = ~clk;

    magia_l2_mem_wrapper #(.NumPorts(4), .MemAw(16), .NumTiles(2), .EocAddr(EOC)) dut (
        .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .be_i(be_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o)
`ifdef MAGIA_L2_EOC_MONITOR_EN
        , .eoc_o(eoc_o), .exit_code_o(exit_code_o)
`endif
    );

    task automatic drv(input int p, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
        req_i[p] = r; we_i[p] = w; addr_i[p] = a; wdata_i[p] = d; be_i[p] = b;
    endtask

    task automatic idle();
        req_i = '0; we_i = '0; addr_i = '0; wdata_i = '0; be_i = '0;
    endtask

    // Checks the current cycle (grant and pending response), records the new grant, advances one clock.
    task automatic cycle(input logic [3:0] eg);
        rsp_t             e;
        logic [3:0]       ev;
        logic [3:0][31:0] ed;
        int               wi;
        #1;
        ev = '0;
        ed = '0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (!rst_i) begin
                ev[e.port] = 1'b1;
                ed[e.port] = e.data;
            end
        end
        vectors++;
        assert (gnt_o === eg) else begin errs++; $error("FAIL gnt obs=%b exp=%b", gnt_o, eg); end
        vectors++;
        assert (rvalid_o === ev) else begin errs++; $error("FAIL rvalid obs=%b exp=%b", rvalid_o, ev); end
        vectors++;
        assert (rdata_o === ed) else begin errs++; $error("FAIL rdata obs=%h exp=%h", rdata_o, ed); end
        for (int p = 0; p < 4; p++) begin
            if (eg[p]) begin
                wi = int'(addr_i[p][15:2]);
                if (!model.exists(wi)) model[wi] = 'x;
                if (we_i[p]) begin
                    for (int k = 0; k < 4; k++)
                        if (be_i[p][k]) model[wi][8*k +: 8] = wdata_i[p][8*k +: 8];
                    sb.push_back('{p, 32'h0});
                end else begin
                    sb.push_back('{p, model[wi]});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        cycle(4'b0000);
        cycle(4'b0000);
`ifdef MAGIA_L2_EOC_MONITOR_EN
        vectors++;
        assert (exit_code_o === 32'h0 && eoc_o === 1'b0) else begin
            errs++; $error("FAIL eoc_reset obs=%h/%b exp=0/0", exit_code_o, eoc_o); end
`endif
        rst_i = 1'b0;
        // write then read back on port 0
        drv(0, 1, 1, 32'h100, 32'hDEADBEEF, 4'hF); cycle(4'b0001);
        drv(0, 1, 0, 32'h100, 32'h0, 4'h0);        cycle(4'b0001);
        idle();                                     cycle(4'b0000);
        // partial byte-enable merge on port 1
        drv(1, 1, 1, 32'h200, 32'hAABBCCDD, 4'hF); cycle(4'b0010);
        drv(1, 1, 1, 32'h200, 32'h11223344, 4'h5); cycle(4'b0010);
        drv(1, 1, 0, 32'h200, 32'h0, 4'h0);        cycle(4'b0010);
        idle();                                     cycle(4'b0000);
        // be=0 write leaves the word untouched
        drv(3, 1, 1, 32'h100, 32'hFFFFFFFF, 4'h0); cycle(4'b1000);
        drv(3, 1, 0, 32'h100, 32'h0, 4'h0);        cycle(4'b1000);
        idle();                                     cycle(4'b0000);
        // aliasing of upper and low address bits
        drv(2, 1, 1, 32'h0001_0303, 32'h12345678, 4'hF); cycle(4'b0100);
        idle(); drv(0, 1, 0, 32'h300, 32'h0, 4'h0);       cycle(4'b0001);
        idle();                                           cycle(4'b0000);
        // pointer at 1: port 2 beats port 0, port 0 holds and wins next
        drv(0, 1, 0, 32'h100, 32'h0, 4'h0);
        drv(2, 1, 0, 32'h300, 32'h0, 4'h0);        cycle(4'b0100);
        drv(2, 0, 0, 32'h0, 32'h0, 4'h0);          cycle(4'b0001);
        idle();                                     cycle(4'b0000);
        // reset right after a granted read suppresses its response
        drv(2, 1, 0, 32'h200, 32'h0, 4'h0);        cycle(4'b0100);
        idle(); rst_i = 1'b1;                       cycle(4'b0000);
        drv(0, 1, 0, 32'h100, 32'h0, 4'h0);        cycle(4'b0000);
        rst_i = 1'b0;
        drv(3, 1, 0, 32'h200, 32'h0, 4'h0);        cycle(4'b0001);
        drv(0, 0, 0, 32'h0, 32'h0, 4'h0);          cycle(4'b1000);
        idle();                                     cycle(4'b0000);
        // all four ports hold reads from reset
        rst_i = 1'b1;                               cycle(4'b0000);
        rst_i = 1'b0;
        drv(0, 1, 0, 32'h100, 32'h0, 4'h0);
        drv(1, 1, 0, 32'h200, 32'h0, 4'h0);
        drv(2, 1, 0, 32'h102, 32'h0, 4'h0);
        drv(3, 1, 0, 32'h0001_0200, 32'h0, 4'h0);
        for (int n = 0; n < 8; n++) cycle(4'b0001 << (n % 4));
        idle();                                     cycle(4'b0000);
`ifdef MAGIA_L2_EOC_MONITOR_EN
        drv(0, 1, 1, EOC, 32'h0001_0000, 4'hC);    cycle(4'b0001);
        idle();                                     cycle(4'b0000);
        vectors++;
        assert (exit_code_o === 32'h0001_0000 && eoc_o === 1'b0) else begin
            errs++; $error("FAIL eoc_slot1 obs=%h/%b exp=00010000/0", exit_code_o, eoc_o); end
        drv(0, 1, 1, EOC, 32'h0000_0001, 4'h3);    cycle(4'b0001);
        vectors++;
        assert (exit_code_o === 32'h0001_0001) else begin
            errs++; $error("FAIL eoc_slot0 obs=%h exp=00010001", exit_code_o); end
        idle();                                     cycle(4'b0000);
        vectors++;
        assert (eoc_o === 1'b1) else begin errs++; $error("FAIL eoc_set obs=%b exp=1", eoc_o); end
        drv(0, 1, 1, EOC, 32'h0, 4'h3);            cycle(4'b0001);
        idle();                                     cycle(4'b0000);
        vectors++;
        assert (eoc_o === 1'b0 && exit_code_o === 32'h0001_0000) else begin
            errs++; $error("FAIL eoc_clear obs=%h/%b exp=00010000/0", exit_code_o, eoc_o); end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/magia_l2_mem_wrapper.md
MAGIA_L2_MEM_WRAPPER -- requirements
Module: magia_l2_mem_wrapper

Interface
REQ-001 Parameter NumPorts, default 4: number of independent memory request ports.
REQ-002 Parameter MemAw, default 16: byte-address bits decoded; capacity 2^MemAw bytes.
REQ-003 Parameter NumTiles, default 16: number of 16-bit exit-code slots.
REQ-004 Parameter EocAddr, default 32'hCC03_0000: byte address of exit-code slot 0; word-aligned.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clk_i  in  1  sole clock, all state on rising edge.
REQ-007 rst_i  in  1  synchronous active-high reset.
REQ-008 req_i  in  NumPorts  per-port access request.
REQ-009 we_i  in  NumPorts  per-port write enable (1 write, 0 read).
REQ-010 addr_i  in  NumPorts x 32  per-port byte address.
REQ-011 wdata_i  in  NumPorts x 32  per-port write data.
REQ-012 be_i  in  NumPorts x 4  per-port byte enables.
REQ-013 gnt_o  out  NumPorts  per-port grant.
REQ-014 rvalid_o  out  NumPorts  per-port response valid.
REQ-015 rdata_o  out  NumPorts x 32  per-port read data.
REQ-016 eoc_o  out  1  end of computation, all exit codes nonzero (macro only).
REQ-017 exit_code_o  out  NumTiles x 16  slot i at bits [16i+15:16i] (macro only).

Function
REQ-018 Single-port byte-organised 32-bit-wide memory; word index = addr_i[MemAw-1:2]; addr_i[1:0] and bits above MemAw-1 ignored (aliasing).
REQ-019 At most one access per cycle; gnt_o is combinational from req_i, one-hot or zero.
REQ-020 Arbitration round-robin: search starts at priority pointer; after a grant pointer = winner+1 mod NumPorts; pointer unchanged when no request.
REQ-021 Requester holds req_i and payload stable until gnt_o; a request deasserted before grant is dropped.
REQ-022 Granted write: byte lane k updated with wdata_i[8k+7:8k] iff be_i[k], at the grant edge; be_i=0 is a legal no-op write.
REQ-023 Granted read: rdata_o of the winning port valid one cycle after grant, with rvalid_o high for exactly that cycle.
REQ-024 Granted write: rvalid_o pulses one cycle after grant; rdata_o = 0.
REQ-025 rdata_o of ports without rvalid_o = 0.
REQ-026 Read one cycle after a write to the same word returns the new data; back-to-back grants every cycle sustained (throughput 1 access/cycle).
REQ-027 Memory array not reset and not initialised by hardware; contents undefined until written.

Reset
REQ-028 While rst_i=1: gnt_o=0, rvalid_o=0, rdata_o=0, pointer=0, exit_code_o=0, eoc_o=0; no memory write occurs.
REQ-029 Reset asserted the cycle after a grant suppresses that pending rvalid_o; memory update already committed at the grant edge is kept.

Configuration
REQ-030 Macro MAGIA_L2_EOC_MONITOR_EN: defined -> exit-code monitor, eoc_o and exit_code_o present; undefined -> those ports, registers and logic absent, memory behaviour identical.
REQ-031 Monitor: slot i occupies byte addresses EocAddr+2i (low) and EocAddr+2i+1 (high), compared on full 32-bit address; any granted write covering those bytes with be set updates the slot register in the same edge as memory.
REQ-032 eoc_o registered: 1 the cycle after all NumTiles slots are nonzero; returns to 0 if any slot is rewritten to zero.

Verification
REQ-033 Port0 write 0xDEADBEEF be=4'hF addr 0x100, next cycle port0 read 0x100 -> gnt same cycle, rvalid next cycle, rdata 0xDEADBEEF.
REQ-034 Write 0x11223344 be=4'b0101 over word 0xAABBCCDD at 0x200, read -> 0xAA22CC44.
REQ-035 All 4 ports hold reads for 8 cycles from reset -> grants ports 0,1,2,3,0,1,2,3; one rvalid per cycle to matching port.
REQ-036 Macro defined, NumTiles=2: write 0x00010000 to EocAddr be=4'hC -> exit_code_o=0x00010000, eoc_o=0; write 0x0001 be=4'h3 to EocAddr -> eoc_o=1 next cycle, exit_code_o=0x00010001.
REQ-037 Read granted, rst_i=1 next cycle -> rvalid_o stays 0; after release, pointer at port 0 and read of previously written word returns stored data.
